// File: rtl/qam_demodulator_if.sv
// qam_demodulator_if -- sample/decision bundle of the QAM sign demodulator.
//   master : drives the sample stream (mixed_signal, in_valid, sym_start)
//            and observes decisions (elojel_sin, elojel_cos, bits_valid,
//            sync_err, busy).
//   slave  : the demodulator side (mirror image of master).
interface qam_demodulator_if #(
  parameter int DATA_W = 16
);
  logic signed [DATA_W-1:0] mixed_signal;
  logic                     in_valid;
  logic                     sym_start;
  logic                     elojel_sin;
  logic                     elojel_cos;
  logic                     bits_valid;
  logic                     sync_err;
  logic                     busy;

  modport master (
    output mixed_signal, in_valid, sym_start,
    input  elojel_sin, elojel_cos, bits_valid, sync_err, busy
  );

  modport slave (
    input  mixed_signal, in_valid, sym_start,
    output elojel_sin, elojel_cos, bits_valid, sync_err, busy
  );
endinterface

// File: rtl/qam_demodulator.sv
// qam_demodulator -- coherent sign detector for a 4-QAM symbol that spans
// exactly one carrier period of SPS samples. Each accepted sample is mixed
// with the sine and cosine references, summed over the symbol, and the sign
// of each sum is reported as one recovered bit per branch.
//
// Ports:
//   clk              rising-edge system clock
//   rst              synchronous active-high reset
//   bus.mixed_signal signed received sample
//   bus.in_valid     sample qualifier
//   bus.sym_start    marks the current valid sample as symbol index 0
//   bus.elojel_sin   sine-branch sign (1 = negative), held between decisions
//   bus.elojel_cos   cosine-branch sign (1 = negative), held between decisions
//   bus.bits_valid   one-cycle strobe when new signs are presented
//   bus.sync_err     one-cycle strobe when sym_start arrives mid-symbol
//   bus.busy         high while in RUN
module qam_demodulator #(
  parameter int SPS    = 32,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  qam_demodulator_if.slave   bus
);

  localparam int IDX_W  = $clog2(SPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + IDX_W + 1;

  typedef enum logic {IDLE, RUN} state_t;

  // Full-period sine table reconstructed from the first quadrant:
  // index 9..15 mirrors 7..1, and the second half-period is negated.
  function automatic logic signed [COEF_W-1:0] sin_rom(input logic [IDX_W-1:0] idx);
    logic [3:0]               h;
    logic [3:0]               j;
    logic signed [COEF_W-1:0] m;
    h = idx[3:0];
    j = (h > 4'd8) ? (4'd0 - h) : h;
    case (j)
      4'd0:    m = 16'sd0;
      4'd1:    m = 16'sd6393;
      4'd2:    m = 16'sd12539;
      4'd3:    m = 16'sd18204;
      4'd4:    m = 16'sd23170;
      4'd5:    m = 16'sd27245;
      4'd6:    m = 16'sd30273;
      4'd7:    m = 16'sd32137;
      4'd8:    m = 16'sd32767;
      default: m = 16'sd0;
    endcase
    return idx[4] ? -m : m;
  endfunction

  state_t                   r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_k;
  logic                     w_busy;

  logic                     w_accept;
  logic                     w_resync;
  logic [IDX_W-1:0]         w_k;
  logic signed [COEF_W-1:0] w_sin_ref, w_cos_ref;
  logic signed [PROD_W-1:0] w_prod_sin, w_prod_cos;

  logic signed [PROD_W-1:0] r_prod_sin_p0, r_prod_cos_p0;
  logic                     r_first_p0, r_last_p0, r_vld_p0;

  logic signed [ACC_W-1:0]  r_acc_sin_p1, r_acc_cos_p1;
  logic signed [ACC_W-1:0]  w_sum_sin, w_sum_cos;
  logic                     r_elojel_sin, r_elojel_cos, r_bits_valid, r_sync_err;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM: next state -- once running, the block never returns to IDLE by itself
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && bus.in_valid && bus.sym_start) w_state_nxt = RUN;
  end

  // FSM: outputs
  always_comb begin
    w_busy = (r_state == RUN);
  end

  // Sample acceptance: sym_start always forces index 0, which both starts a
  // symbol from IDLE and resynchronises (abandoning the partial sum) in RUN.
  always_comb begin
    w_accept = bus.in_valid && ((r_state == RUN) || bus.sym_start);
    w_k      = bus.sym_start ? '0 : r_k;
    w_resync = bus.in_valid && bus.sym_start && (r_state == RUN) && (r_k != '0);
  end

  assign w_sin_ref  = sin_rom(w_k);
  assign w_cos_ref  = sin_rom(w_k + IDX_W'(SPS / 4));
  assign w_prod_sin = PROD_W'(bus.mixed_signal) * PROD_W'(w_sin_ref);
  assign w_prod_cos = PROD_W'(bus.mixed_signal) * PROD_W'(w_cos_ref);

  // ---- stage 1: mix with references, tag first/last sample of symbol ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k           <= '0;
      r_vld_p0      <= 1'b0;
      r_prod_sin_p0 <= '0;
      r_prod_cos_p0 <= '0;
      r_first_p0    <= 1'b0;
      r_last_p0     <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_vld_p0   <= w_accept;
      r_sync_err <= w_resync;
      if (w_accept) begin
        r_k           <= w_k + IDX_W'(1);
        r_prod_sin_p0 <= w_prod_sin;
        r_prod_cos_p0 <= w_prod_cos;
        r_first_p0    <= (w_k == '0);
        r_last_p0     <= (w_k == IDX_W'(SPS - 1));
      end
    end
  end

  // The first sample reloads the accumulator, so a symbol that follows
  // another (or an aborted one) never inherits the previous sum.
  assign w_sum_sin = r_first_p0 ? ACC_W'(r_prod_sin_p0) : r_acc_sin_p1 + ACC_W'(r_prod_sin_p0);
  assign w_sum_cos = r_first_p0 ? ACC_W'(r_prod_cos_p0) : r_acc_cos_p1 + ACC_W'(r_prod_cos_p0);

  // ---- stage 2: accumulate over the symbol, decide sign on last sample ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_sin_p1 <= '0;
      r_acc_cos_p1 <= '0;
      r_elojel_sin <= 1'b0;
      r_elojel_cos <= 1'b0;
      r_bits_valid <= 1'b0;
    end else begin
      r_bits_valid <= r_vld_p0 && r_last_p0;
      if (r_vld_p0) begin
        r_acc_sin_p1 <= w_sum_sin;
        r_acc_cos_p1 <= w_sum_cos;
        // Sign bit only: a sum of exactly zero reads as non-negative.
        if (r_last_p0) begin
          r_elojel_sin <= w_sum_sin[ACC_W-1];
          r_elojel_cos <= w_sum_cos[ACC_W-1];
        end
      end
    end
  end

  assign bus.elojel_sin = r_elojel_sin;
  assign bus.elojel_cos = r_elojel_cos;
  assign bus.bits_valid = r_bits_valid;
  assign bus.sync_err   = r_sync_err;
  assign bus.busy       = w_busy;

endmodule
